// File: rtl/ddr_queue_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read-descriptor port among P_QUEUE_NUM queues; completions routed back by issue-order ID FIFO.
// Optional DDR_RD_ARB_STRICT_PRIO_EN: lowest-index eligible queue always wins (rr pointer unused).

// ID FIFO: remembers the owning queue of each issued read in issue order.
// Latency: pop data is the current head (show-ahead), updates one cycle after push/pop.
// Backpressure: none; caller never pushes when full (credit) nor pops when empty.
module ddr_rd_arb_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose: grant one queue descriptor at a time onto the DDR read port, route completions back.
// Latency: queue valid -> o_m_rd_valid 1 cycle; i_m_rd_cpl -> o_q_rd_cpl 1 cycle; 1 descriptor / 2 cycles max.
// Backpressure: descriptor held until i_m_rd_ready; no grant while P_MAX_OUTSTANDING reads are in flight.
module ddr_queue_rd_arbiter #(
    parameter int P_QUEUE_NUM        = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int P_MAX_OUTSTANDING  = 16,
    parameter int P_QID_WIDTH        = 2
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [P_QUEUE_NUM-1:0]                    i_q_rd_valid,
    output logic [P_QUEUE_NUM-1:0]                    o_q_rd_ready,
    input  logic [P_QUEUE_NUM*C_M_AXI_ADDR_WIDTH-1:0] i_q_rd_addr,
    input  logic [P_QUEUE_NUM*16-1:0]                 i_q_rd_len,
    input  logic [P_QUEUE_NUM*8-1:0]                  i_q_rd_strb,
    output logic [P_QUEUE_NUM-1:0]                    o_q_rd_cpl,
    output logic                                      o_m_rd_valid,
    input  logic                                      i_m_rd_ready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]             o_m_rd_addr,
    output logic [15:0]                               o_m_rd_len,
    output logic [7:0]                                o_m_rd_strb,
    output logic [P_QID_WIDTH-1:0]                    o_m_rd_qid,
    input  logic                                      i_m_rd_cpl,
    output logic [6:0]                                o_outstanding,
    output logic                                      o_cpl_err
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state;
    logic                   credit_ok;
    logic                   win_vld;
    logic [P_QID_WIDTH-1:0] winner;
    logic                   lo_vld;
    logic [P_QID_WIDTH-1:0] lo_idx;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic [P_QID_WIDTH-1:0] head_qid;
`ifndef DDR_RD_ARB_STRICT_PRIO_EN
    logic [P_QID_WIDTH-1:0] rr_ptr;
    logic                   hi_vld;
    logic [P_QID_WIDTH-1:0] hi_idx;
`endif

    assign credit_ok = (o_outstanding < 7'(P_MAX_OUTSTANDING));
    assign push      = (state == ISSUE) && i_m_rd_ready;
    assign pop       = i_m_rd_cpl && !fifo_empty;

    // Downward scan so the last hit is the lowest index; hi_* restricts to indices at/above rr_ptr.
    always_comb begin
        lo_vld = 1'b0;
        lo_idx = '0;
`ifndef DDR_RD_ARB_STRICT_PRIO_EN
        hi_vld = 1'b0;
        hi_idx = '0;
`endif
        for (int n = P_QUEUE_NUM - 1; n >= 0; n--) begin
            if (i_q_rd_valid[n]) begin
                lo_vld = 1'b1;
                lo_idx = P_QID_WIDTH'(n);
            end
`ifndef DDR_RD_ARB_STRICT_PRIO_EN
            if (i_q_rd_valid[n] && (P_QID_WIDTH'(n) >= rr_ptr)) begin
                hi_vld = 1'b1;
                hi_idx = P_QID_WIDTH'(n);
            end
`endif
        end
`ifdef DDR_RD_ARB_STRICT_PRIO_EN
        winner = lo_idx;
`else
        winner = hi_vld ? hi_idx : lo_idx;
`endif
        win_vld = lo_vld && credit_ok && (state == IDLE) && !i_rst;
    end

    always_comb begin
        o_q_rd_ready = '0;
        if (win_vld) o_q_rd_ready[winner] = 1'b1;
    end

    ddr_rd_arb_fifo #(
        .WIDTH (P_QID_WIDTH),
        .DEPTH (P_MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (push),
        .push_dat (o_m_rd_qid),
        .pop      (pop),
        .pop_dat  (head_qid),
        .empty    (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            o_m_rd_valid  <= 1'b0;
            o_m_rd_addr   <= '0;
            o_m_rd_len    <= '0;
            o_m_rd_strb   <= '0;
            o_m_rd_qid    <= '0;
            o_q_rd_cpl    <= '0;
            o_outstanding <= '0;
            o_cpl_err     <= 1'b0;
`ifndef DDR_RD_ARB_STRICT_PRIO_EN
            rr_ptr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        o_m_rd_addr  <= i_q_rd_addr[winner*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
                        o_m_rd_len   <= i_q_rd_len[winner*16 +: 16];
                        o_m_rd_strb  <= i_q_rd_strb[winner*8 +: 8];
                        o_m_rd_qid   <= winner;
                        o_m_rd_valid <= 1'b1;
                        state        <= ISSUE;
`ifndef DDR_RD_ARB_STRICT_PRIO_EN
                        rr_ptr       <= (winner == P_QID_WIDTH'(P_QUEUE_NUM - 1)) ? '0 : winner + 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    if (i_m_rd_ready) begin
                        o_m_rd_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            o_q_rd_cpl <= '0;
            if (pop) o_q_rd_cpl[head_qid] <= 1'b1;
            if (i_m_rd_cpl && fifo_empty) o_cpl_err <= 1'b1;

            case ({push, pop})
                2'b10:   o_outstanding <= o_outstanding + 7'd1;
                2'b01:   o_outstanding <= o_outstanding - 7'd1;
                default: o_outstanding <= o_outstanding;
            endcase
        end
    end
endmodule
